mem_decode: RTL

- Parametrised, registered successor to the combinational chip-select decoder on the 6502 bus.
- Decodes the top address nibble against a run-time programmable region table and drives active-low chip selects.
- Generates per-region wait states on RDY for slow devices (ROM, serial).
- Sits in the CPLD between the CPU address bus and the memory/peripheral selects.

---
 rtl/mem_decode_pkg.sv | 43 ++++
 rtl/mem_decode_if.sv | 40 ++++
 rtl/mem_decode_region_match.sv | 15 +
 rtl/mem_decode.sv | 109 ++++++++++
 4 files changed

// File: rtl/mem_decode_pkg.sv
// Shared types and the power-on region map for the bus chip-select decoder.
// The default map assumes 4 KiB granules (4 decoded address bits).
package mem_decode_pkg;

    localparam int MAX_NREG = 16;
    localparam int MAX_AW   = 16;
    localparam int MAX_WW   = 8;
    localparam int IDX_W    = $clog2(MAX_NREG);

    typedef struct packed {
        logic [MAX_AW-1:0] lo;
        logic [MAX_AW-1:0] hi;
        logic [MAX_WW-1:0] wstates;
        logic              valid;
    } region_t;

    localparam logic [MAX_AW-1:0] DEF_LO [MAX_NREG] = '{
        16'h0, 16'hA, 16'hB, 16'hC, 16'hD, 16'hE, 16'h0, 16'h0,
        16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0
    };

    localparam logic [MAX_AW-1:0] DEF_HI [MAX_NREG] = '{
        16'h7, 16'hA, 16'hB, 16'hC, 16'hD, 16'hF, 16'h0, 16'h0,
        16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0
    };

    localparam logic [MAX_WW-1:0] DEF_WAIT [MAX_NREG] = '{
        8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0,
        8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0
    };

    localparam logic [MAX_NREG-1:0] DEF_VALID = 16'h003F;

    function automatic region_t def_region(input int i);
        region_t r;
        r.lo      = DEF_LO[i];
        r.hi      = DEF_HI[i];
        r.wstates = DEF_WAIT[i];
        r.valid   = DEF_VALID[i];
        return r;
    endfunction

endpackage

// File: rtl/mem_decode_if.sv
// CPU-side bus and table-programming signals of the chip-select decoder.
// master drives address/config, slave returns selects and RDY.
interface mem_decode_if
    import mem_decode_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int NREG   = 6,
    parameter int WAIT_W = 3
);

    logic              enable;
    logic              cycle_start;
    logic [ADDR_W-1:0] addr;

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [ADDR_W-1:0] cfg_lo;
    logic [ADDR_W-1:0] cfg_hi;
    logic [WAIT_W-1:0] cfg_wait;
    logic              cfg_valid;

    logic [NREG-1:0]   cs_n;
    logic              rdy;
    logic              hit;

    modport master (
        output enable, cycle_start, addr,
        output cfg_we, cfg_idx, cfg_lo, cfg_hi,
        output cfg_wait, cfg_valid,
        input  cs_n, rdy, hit
    );

    modport slave (
        input  enable, cycle_start, addr,
        input  cfg_we, cfg_idx, cfg_lo, cfg_hi,
        input  cfg_wait, cfg_valid,
        output cs_n, rdy, hit
    );

endinterface

// File: rtl/mem_decode_region_match.sv
// Single-region range comparator: inclusive unsigned bounds, gated by valid.
// An inverted range (lo > hi) can never satisfy both compares.
module region_match #(
    parameter int AW = 4
) (
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    input  logic          valid,
    output logic          match
);

    assign match = valid && (lo <= addr) && (addr <= hi);

endmodule

// File: rtl/mem_decode.sv
// Registered chip-select decoder with a programmable region table and
// per-region RDY wait states for slow devices on the 6502 bus.
module mem_decode
    import mem_decode_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int NREG   = 6,
    parameter int WAIT_W = 3
) (
    input  logic clk,
    input  logic reset,
    mem_decode_if.slave bus
);

    region_t           tab_q [NREG];
    region_t           wr_ent;

    logic [MAX_AW-1:0] addr_x;
    logic [NREG-1:0]   match;
    logic [NREG-1:0]   sel;
    logic [MAX_WW-1:0] wait_win;

    logic [NREG-1:0]   cs_n_q;
    logic [NREG-1:0]   cs_n_d;
    logic              hit_q;
    logic              hit_d;
    logic [MAX_WW-1:0] cnt_q;
    logic [MAX_WW-1:0] cnt_d;
    logic              take;

    // Table entries are kept at full record width; upper bits stay zero.
    assign addr_x         = MAX_AW'(bus.addr);
    assign wr_ent.lo      = MAX_AW'(bus.cfg_lo);
    assign wr_ent.hi      = MAX_AW'(bus.cfg_hi);
    assign wr_ent.wstates = MAX_WW'(bus.cfg_wait);
    assign wr_ent.valid   = bus.cfg_valid;

    for (genvar g = 0; g < NREG; g++) begin : g_match
        region_match #(
            .AW (MAX_AW)
        ) u_match (
            .addr  (addr_x),
            .lo    (tab_q[g].lo),
            .hi    (tab_q[g].hi),
            .valid (tab_q[g].valid),
            .match (match[g])
        );
    end

    // Walk downwards so the lowest matching index is the last to land.
    always_comb begin
        sel      = '0;
        wait_win = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel      = '0;
                sel[i]   = 1'b1;
                wait_win = tab_q[i].wstates;
            end
        end
    end

    // A strobe during a stall repeats the same address, so it is dropped.
    assign take = bus.cycle_start && (cnt_q == '0);

    always_comb begin
        cs_n_d = cs_n_q;
        hit_d  = hit_q;
        cnt_d  = cnt_q;
        if (take) begin
            if (bus.enable && (|match)) begin
                cs_n_d = ~sel;
                hit_d  = 1'b1;
                cnt_d  = wait_win;
            end else begin
                cs_n_d = '1;
                hit_d  = 1'b0;
                cnt_d  = '0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MAX_WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q <= '1;
            hit_q  <= 1'b0;
            cnt_q  <= '0;
            for (int i = 0; i < NREG; i++) begin
                tab_q[i] <= def_region(i);
            end
        end else begin
            cs_n_q <= cs_n_d;
            hit_q  <= hit_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < NREG; i++) begin
                if (bus.cfg_we && (bus.cfg_idx == IDX_W'(i))) begin
                    tab_q[i] <= wr_ent;
                end
            end
        end
    end

    assign bus.cs_n = cs_n_q;
    assign bus.rdy  = (cnt_q == '0);
    assign bus.hit  = hit_q;

endmodule
